// File: rtl/ff_reg_pkg.sv
// Shared definitions for the force-format serial output register:
// format-select encodings and the output-formatting rule.
package ff_reg_pkg;

   localparam logic [1:0] FF_NRZ    = 2'b00;
   localparam logic [1:0] FF_NRZI   = 2'b01;
   localparam logic [1:0] FF_FORCE0 = 2'b10;
   localparam logic [1:0] FF_FORCE1 = 2'b11;

   // NRZI keeps its state in the output flop itself, so a switch into NRZI
   // naturally continues from whatever level the pin currently shows.
   function automatic logic next_out(input logic [1:0] mode,
                                     input logic       bit_in,
                                     input logic       cur);
      logic nxt;
      nxt = cur;
      case (mode)
         FF_NRZ:    nxt = bit_in;
         FF_NRZI:   nxt = cur ^ bit_in;
         FF_FORCE0: nxt = 1'b0;
         FF_FORCE1: nxt = 1'b1;
         default:   nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/force_format_delay.sv
// DEPTH-stage enabled shift line with asynchronous active-low clear;
// feeds the formatter with the oldest stage.
module force_format_delay #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
      end else if (en) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/force_format_reg.sv
// Serial output register: delayed data is formatted as NRZ, NRZI, forced 0
// or forced 1 and driven straight from a flop to the pin.
module force_format_reg
   import ff_reg_pkg::*;
#(
   parameter int   DEPTH     = 1,
   parameter logic RST_LEVEL = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CLK_ENABLE,
   input  logic       DATA,
   input  logic [1:0] FF,
   output logic       OUT
);

   logic fmt_bit;

   // Delay line shifts in every mode so a return to NRZ shows fresh data.
   force_format_delay #(
      .DEPTH (DEPTH)
   ) u_delay (
      .clk   (CLK),
      .rst_n (RST),
      .en    (CLK_ENABLE),
      .din   (DATA),
      .dout  (fmt_bit)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OUT <= RST_LEVEL;
      end else if (CLK_ENABLE) begin
         OUT <= next_out(FF, fmt_bit, OUT);
      end
   end

endmodule

// File: tb/tb_force_format_reg.sv
// Directed-vector bench for force_format_reg (default DEPTH=1, RST_LEVEL=0).
module tb_force_format_reg;

   logic       CLK;
   logic       RST;
   logic       CLK_ENABLE;
   logic       DATA;
   logic [1:0] FF;
   logic       OUT;

   int vectors = 0;
   int miscompares = 0;

   force_format_reg u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .CLK_ENABLE (CLK_ENABLE),
      .DATA       (DATA),
      .FF         (FF),
      .OUT        (OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic got, input logic exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one bit, then land 1 time unit after the next rising edge.
   task automatic step(input logic d);
      DATA = d;
      @(posedge CLK);
      #1;
   endtask

   logic [4:0] nrz_in;
   logic [3:0] nrzi_in;
   logic [3:0] nrzi_exp;

   initial begin
      // Test 1: reset dominates enable, DATA=1 and force-1.
      RST = 1'b0; CLK_ENABLE = 1'b1; DATA = 1'b1; FF = 2'b11;
      #1;
      chk("rst_immediate", OUT, 1'b0);
      step(1'b1);
      chk("rst_hold_e1", OUT, 1'b0);
      step(1'b1);
      chk("rst_hold_e2", OUT, 1'b0);
      RST = 1'b1; FF = 2'b00;

      // Test 2: NRZ, bits appear two enabled edges after being applied.
      nrz_in = 5'b01101;  // applied LSB first: 1,0,1,1,0
      for (int i = 0; i <= 5; i++) begin
         step(i < 5 ? nrz_in[i] : 1'b0);
         if (i == 0) chk("nrz_first_edge", OUT, 1'b0);
         else        chk($sformatf("nrz_bit%0d", i - 1), OUT, nrz_in[i-1]);
      end

      // Test 3: NRZI from OUT=0, DATA 1,1,0,1 -> OUT 1,0,0,1 delayed.
      FF = 2'b01;
      nrzi_in  = 4'b1011;  // LSB first: 1,1,0,1
      nrzi_exp = 4'b1001;  // LSB first: 1,0,0,1
      step(nrzi_in[0]);
      chk("nrzi_first_edge", OUT, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step(i < 4 ? nrzi_in[i] : 1'b0);
         chk($sformatf("nrzi_out%0d", i - 1), OUT, nrzi_exp[i-1]);
      end

      // Test 4: force 0, force 1, then back to NRZ with fresh data.
      FF = 2'b10;
      step(1'b1); chk("force0_e1", OUT, 1'b0);
      step(1'b0); chk("force0_e2", OUT, 1'b0);
      FF = 2'b11;
      step(1'b1); chk("force1_e1", OUT, 1'b1);
      step(1'b1); chk("force1_e2", OUT, 1'b1);
      FF = 2'b00;
      step(1'b0); chk("nrz_resume_e1", OUT, 1'b1);
      step(1'b1); chk("nrz_resume_e2", OUT, 1'b0);
      step(1'b0); chk("nrz_resume_e3", OUT, 1'b1);

      // Test 5: disabled edges hold everything, FF ignored meanwhile.
      CLK_ENABLE = 1'b1;
      step(1'b1); chk("en_on_a", OUT, 1'b0);
      CLK_ENABLE = 1'b0; FF = 2'b11;
      step(1'b0); chk("en_off_a", OUT, 1'b0);
      step(1'b0); chk("en_off_b", OUT, 1'b0);
      CLK_ENABLE = 1'b1; FF = 2'b00;
      step(1'b0); chk("en_on_b_kept_bit", OUT, 1'b1);
      step(1'b0); chk("en_on_c", OUT, 1'b0);

      // Test 6: async reset mid-NRZI stream, then restart.
      FF = 2'b01;
      step(1'b1); chk("nrzi2_e1", OUT, 1'b0);
      step(1'b1); chk("nrzi2_e2", OUT, 1'b1);
      #2 RST = 1'b0;
      #1 chk("rst_async", OUT, 1'b0);
      step(1'b1); chk("rst_mid_hold", OUT, 1'b0);
      RST = 1'b1;
      step(1'b1); chk("post_rst_e1", OUT, 1'b0);
      step(1'b1); chk("post_rst_e2", OUT, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
